// File: rtl/gen3_scrambler_lane_pkg.sv
// Shared PHY definitions for the Gen3 (128b/130b) lane data path:
// sync header codes, ordered-set identifier symbols, block types and
// the block-start word classifier.
package gen3_scrambler_lane_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_OS   = 2'b01;

  localparam logic [7:0] SKP_SYM0   = 8'hAA;
  localparam logic [7:0] EIEOS_SYM0 = 8'h00;

  // Raw encodings kept as plain constants so older blocks that compare
  // against bit patterns keep working alongside the enum.
  localparam logic [2:0] BT_IDLE  = 3'd0;
  localparam logic [2:0] BT_DATA  = 3'd1;
  localparam logic [2:0] BT_OS    = 3'd2;
  localparam logic [2:0] BT_SKP   = 3'd3;
  localparam logic [2:0] BT_EIEOS = 3'd4;

  typedef enum logic [2:0] {
    BLK_IDLE  = BT_IDLE,
    BLK_DATA  = BT_DATA,
    BLK_OS    = BT_OS,
    BLK_SKP   = BT_SKP,
    BLK_EIEOS = BT_EIEOS
  } block_type_e;

  // Classifies a block from its sync header and first symbol. A sync
  // header that is neither data nor ordered set is treated as a plain
  // ordered set; the caller flags it as a framing error.
  function automatic block_type_e classify_block(
    input logic [1:0] sync_header,
    input logic [7:0] sym0,
    input logic [7:0] skp_sym,
    input logic [7:0] eieos_sym
  );
    block_type_e bt;
    if (sync_header == SYNC_DATA) begin
      bt = BLK_DATA;
    end else if (sync_header == SYNC_OS) begin
      if (sym0 == skp_sym) begin
        bt = BLK_SKP;
      end else if (sym0 == eieos_sym) begin
        bt = BLK_EIEOS;
      end else begin
        bt = BLK_OS;
      end
    end else begin
      bt = BLK_OS;
    end
    return bt;
  endfunction

endpackage

// File: rtl/gen3_scrambler_lane.sv
// Per-lane 8GT/s scrambler data path. Data-block words are XORed with
// the key from the lane LFSR generator, ordered-set words pass through,
// and the generator's advance/reseed controls are derived here. Output
// is registered one cycle ahead of the 130b gearbox.
module gen3_scrambler_lane
  import gen3_scrambler_lane_pkg::*;
#(
  parameter int         BLOCK_WORDS = 4,
  parameter logic [7:0] EIEOS_SYM0  = gen3_scrambler_lane_pkg::EIEOS_SYM0,
  parameter logic [7:0] SKP_SYM0    = gen3_scrambler_lane_pkg::SKP_SYM0
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_start_block,
  input  logic [1:0]  tx_sync_header,
  input  logic [31:0] key_in,
  output logic        lfsr_advance,
  output logic        lfsr_reset,
  output logic [31:0] scr_data,
  output logic        scr_valid,
  output logic        scr_start_block,
  output logic [1:0]  scr_sync_header,
  output logic        block_err
);

  localparam logic [1:0] WCNT_LAST = 2'(BLOCK_WORDS - 1);

  block_type_e blk_state;
  block_type_e word_class;
  logic [1:0]  wcnt;
  logic        start_word;
  logic        cont_word;
  logic        stray_word;
  logic        last_word;
  logic        sync_bad;

  // Classify the word presented this cycle; BLK_IDLE means no word is
  // accepted (bubble, or a stray word outside any block).
  always_comb begin
    start_word = tx_valid && tx_start_block;
    cont_word  = tx_valid && !tx_start_block && (blk_state != BLK_IDLE);
    stray_word = tx_valid && !tx_start_block && (blk_state == BLK_IDLE);
    sync_bad   = (tx_sync_header != SYNC_DATA) && (tx_sync_header != SYNC_OS);
    last_word  = cont_word && (wcnt == WCNT_LAST);
    word_class = BLK_IDLE;
    if (start_word) begin
      word_class = classify_block(tx_sync_header, tx_data[7:0], SKP_SYM0, EIEOS_SYM0);
    end else if (cont_word) begin
      word_class = blk_state;
    end
  end

  // The key steps for every accepted word except those of a SKP block.
  assign lfsr_advance = (word_class != BLK_IDLE) && (word_class != BLK_SKP);

  // Block type and word position; a new start always wins, abandoning
  // any partial block.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      blk_state <= BLK_IDLE;
      wcnt      <= 2'd0;
    end else if (start_word) begin
      blk_state <= word_class;
      wcnt      <= 2'd1;
    end else if (last_word) begin
      blk_state <= BLK_IDLE;
      wcnt      <= 2'd0;
    end else if (cont_word) begin
      wcnt      <= wcnt + 2'd1;
    end
  end

  // Registered output word, framing markers, reseed pulse and errors.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      scr_data        <= 32'd0;
      scr_valid       <= 1'b0;
      scr_start_block <= 1'b0;
      scr_sync_header <= 2'b00;
      lfsr_reset      <= 1'b0;
      block_err       <= 1'b0;
    end else begin
      scr_valid       <= (word_class != BLK_IDLE);
      scr_start_block <= start_word;
      scr_sync_header <= start_word ? tx_sync_header : 2'b00;
      lfsr_reset      <= last_word && (blk_state == BLK_EIEOS);
      block_err       <= stray_word || (start_word && ((wcnt != 2'd0) || sync_bad));
      if (word_class == BLK_DATA) begin
        scr_data <= tx_data ^ key_in;
      end else if (word_class != BLK_IDLE) begin
        scr_data <= tx_data;
      end
    end
  end

endmodule

// File: tb/tb_gen3_scrambler_lane.sv
// Directed self-checking bench for gen3_scrambler_lane. Inputs change on
// the falling edge; lfsr_advance is checked before the next rising edge,
// registered outputs 1 ns after it.
module tb_gen3_scrambler_lane;

  logic        pclk;
  logic        reset_n;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_start_block;
  logic [1:0]  tx_sync_header;
  logic [31:0] key_in;
  logic        lfsr_advance;
  logic        lfsr_reset;
  logic [31:0] scr_data;
  logic        scr_valid;
  logic        scr_start_block;
  logic [1:0]  scr_sync_header;
  logic        block_err;

  int vectors;
  int miscompares;

  gen3_scrambler_lane dut (
    .pclk            (pclk),
    .reset_n         (reset_n),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_start_block  (tx_start_block),
    .tx_sync_header  (tx_sync_header),
    .key_in          (key_in),
    .lfsr_advance    (lfsr_advance),
    .lfsr_reset      (lfsr_reset),
    .scr_data        (scr_data),
    .scr_valid       (scr_valid),
    .scr_start_block (scr_start_block),
    .scr_sync_header (scr_sync_header),
    .block_err       (block_err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Present one word on the falling edge.
  task automatic applyStimulus(input logic v, input logic s, input logic [1:0] h,
                               input logic [31:0] d, input logic [31:0] k);
    @(negedge pclk);
    tx_valid       = v;
    tx_start_block = s;
    tx_sync_header = h;
    tx_data        = d;
    key_in         = k;
    #1;
  endtask

  // Let the presented word be captured, then settle.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tx_valid = 1'b0; tx_start_block = 1'b0; tx_sync_header = 2'b00;
    tx_data = 32'd0; key_in = 32'd0;
    repeat (2) @(posedge pclk);
    #1;
    vectors++; if (scr_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset scr_data got %h exp 0", scr_data); end
    vectors++; if (scr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset scr_valid got %b exp 0", scr_valid); end
    vectors++; if (scr_start_block !== 1'b0) begin miscompares++; $display("[TB] FAIL reset scr_start_block got %b exp 0", scr_start_block); end
    vectors++; if (scr_sync_header !== 2'b00) begin miscompares++; $display("[TB] FAIL reset scr_sync_header got %b exp 00", scr_sync_header); end
    vectors++; if (lfsr_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL reset lfsr_reset got %b exp 0", lfsr_reset); end
    vectors++; if (block_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset block_err got %b exp 0", block_err); end
    vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL reset lfsr_advance got %b exp 0", lfsr_advance); end
    @(negedge pclk);
    reset_n = 1'b1;
  endtask

  task automatic test_data_block();
    logic [31:0] k;
    for (int i = 0; i < 4; i++) begin
      k = 32'hA5A5_0001 + 32'(i);
      applyStimulus(1'b1, i == 0, 2'b10, 32'd0, k);
      vectors++; if (lfsr_advance !== 1'b1) begin miscompares++; $display("[TB] FAIL data adv w%0d got %b exp 1", i, lfsr_advance); end
      step();
      vectors++; if (scr_data !== k) begin miscompares++; $display("[TB] FAIL data scr_data w%0d got %h exp %h", i, scr_data, k); end
      vectors++; if (scr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL data scr_valid w%0d got %b exp 1", i, scr_valid); end
      vectors++; if (block_err !== 1'b0) begin miscompares++; $display("[TB] FAIL data block_err w%0d got %b exp 0", i, block_err); end
      vectors++; if (scr_start_block !== (i == 0)) begin miscompares++; $display("[TB] FAIL data scr_start w%0d got %b exp %b", i, scr_start_block, i == 0); end
      if (i == 0) begin
        vectors++; if (scr_sync_header !== 2'b10) begin miscompares++; $display("[TB] FAIL data sync got %b exp 10", scr_sync_header); end
      end
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL data bubble adv got %b exp 0", lfsr_advance); end
    step();
    vectors++; if (scr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL data bubble valid got %b exp 0", scr_valid); end
  endtask

  task automatic test_skp();
    logic [31:0] d [4];
    d[0] = 32'hAAAA_AAAA; d[1] = 32'hAAAA_AAAA; d[2] = 32'hAAAA_AAAA; d[3] = 32'hE1AA_55AA;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i == 0, 2'b01, d[i], 32'hDEAD_BEEF);
      vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL skp adv w%0d got %b exp 0", i, lfsr_advance); end
      step();
      vectors++; if (scr_data !== d[i]) begin miscompares++; $display("[TB] FAIL skp scr_data w%0d got %h exp %h", i, scr_data, d[i]); end
      vectors++; if (lfsr_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL skp lfsr_reset w%0d got %b exp 0", i, lfsr_reset); end
      vectors++; if (block_err !== 1'b0) begin miscompares++; $display("[TB] FAIL skp block_err w%0d got %b exp 0", i, block_err); end
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
    vectors++; if (lfsr_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL skp post lfsr_reset got %b exp 0", lfsr_reset); end
  endtask

  task automatic test_eieos();
    logic [31:0] d [4];
    d[0] = 32'h0000_FF00; d[1] = 32'hFF00_FF00; d[2] = 32'hFF00_FF00; d[3] = 32'hFF00_FF00;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i == 0, 2'b01, d[i], 32'h1357_9BDF);
      vectors++; if (lfsr_advance !== 1'b1) begin miscompares++; $display("[TB] FAIL eieos adv w%0d got %b exp 1", i, lfsr_advance); end
      step();
      vectors++; if (scr_data !== d[i]) begin miscompares++; $display("[TB] FAIL eieos scr_data w%0d got %h exp %h", i, scr_data, d[i]); end
      vectors++; if (lfsr_reset !== (i == 3)) begin miscompares++; $display("[TB] FAIL eieos lfsr_reset w%0d got %b exp %b", i, lfsr_reset, i == 3); end
    end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
    vectors++; if (lfsr_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL eieos pulse width got %b exp 0", lfsr_reset); end
  endtask

  task automatic test_restart();
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h1111_1111, 32'h0F0F_0F0F);
    step();
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h2222_2222, 32'h0F0F_0F0F);
    step();
    applyStimulus(1'b1, 1'b1, 2'b10, 32'h3333_3333, 32'h00FF_00FF);
    step();
    vectors++; if (block_err !== 1'b1) begin miscompares++; $display("[TB] FAIL restart block_err got %b exp 1", block_err); end
    vectors++; if (scr_data !== 32'h33CC_33CC) begin miscompares++; $display("[TB] FAIL restart scr_data got %h exp 33cc33cc", scr_data); end
    vectors++; if (scr_start_block !== 1'b1) begin miscompares++; $display("[TB] FAIL restart scr_start got %b exp 1", scr_start_block); end
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h4444_0000 + 32'(i), 32'hFFFF_0000);
      step();
      vectors++; if (block_err !== 1'b0) begin miscompares++; $display("[TB] FAIL restart err w%0d got %b exp 0", i, block_err); end
      vectors++; if (scr_data !== (32'hBBBB_0000 + 32'(i))) begin miscompares++; $display("[TB] FAIL restart data w%0d got %h exp %h", i, scr_data, 32'hBBBB_0000 + 32'(i)); end
    end
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h5555_5555, 32'd0);
    vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL resync stray adv got %b exp 0", lfsr_advance); end
    step();
    vectors++; if (block_err !== 1'b1) begin miscompares++; $display("[TB] FAIL resync stray err got %b exp 1", block_err); end
    vectors++; if (scr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL resync stray valid got %b exp 0", scr_valid); end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
  endtask

  task automatic test_bubbles();
    logic [31:0] d [6];
    logic [31:0] k [6];
    logic        v [6];
    int          nvalid;
    d[0] = 32'h1234_5678; k[0] = 32'h1111_1111; v[0] = 1'b1;
    d[1] = 32'h9ABC_DEF0; k[1] = 32'h2222_2222; v[1] = 1'b1;
    d[2] = 32'h0000_0000; k[2] = 32'hFFFF_FFFF; v[2] = 1'b0;
    d[3] = 32'h0000_0000; k[3] = 32'hFFFF_FFFF; v[3] = 1'b0;
    d[4] = 32'h0F0F_0F0F; k[4] = 32'h3333_3333; v[4] = 1'b1;
    d[5] = 32'hF0F0_F0F0; k[5] = 32'h4444_4444; v[5] = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[i], i == 0, 2'b10, d[i], k[i]);
      vectors++; if (lfsr_advance !== v[i]) begin miscompares++; $display("[TB] FAIL bubble adv c%0d got %b exp %b", i, lfsr_advance, v[i]); end
      step();
      if (scr_valid === 1'b1) nvalid++;
      if (v[i]) begin
        vectors++; if (scr_data !== (d[i] ^ k[i])) begin miscompares++; $display("[TB] FAIL bubble data c%0d got %h exp %h", i, scr_data, d[i] ^ k[i]); end
      end
    end
    vectors++; if (nvalid != 4) begin miscompares++; $display("[TB] FAIL bubble count got %0d exp 4", nvalid); end
    applyStimulus(1'b1, 1'b0, 2'b10, 32'hAAAA_0000, 32'd0);
    step();
    vectors++; if (block_err !== 1'b1) begin miscompares++; $display("[TB] FAIL bubble block end err got %b exp 1", block_err); end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
  endtask

  task automatic test_reset_mid_block();
    applyStimulus(1'b1, 1'b1, 2'b10, 32'hCAFE_0000, 32'h0000_0001);
    step();
    applyStimulus(1'b1, 1'b0, 2'b10, 32'hCAFE_0001, 32'h0000_0002);
    step();
    vectors++; if (scr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL prereset valid got %b exp 1", scr_valid); end
    applyStimulus(1'b1, 1'b0, 2'b10, 32'hCAFE_0002, 32'h0000_0003);
    reset_n = 1'b0;
    #1;
    vectors++; if (scr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset valid got %b exp 0", scr_valid); end
    vectors++; if (scr_data !== 32'd0) begin miscompares++; $display("[TB] FAIL midreset data got %h exp 0", scr_data); end
    vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset adv got %b exp 0", lfsr_advance); end
    @(negedge pclk);
    tx_valid = 1'b0;
    reset_n  = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b10, 32'hCAFE_0003, 32'h0000_0004);
    vectors++; if (lfsr_advance !== 1'b0) begin miscompares++; $display("[TB] FAIL postreset adv got %b exp 0", lfsr_advance); end
    step();
    vectors++; if (scr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL postreset valid got %b exp 0", scr_valid); end
    vectors++; if (block_err !== 1'b1) begin miscompares++; $display("[TB] FAIL postreset err got %b exp 1", block_err); end
    applyStimulus(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_data_block();
    test_skp();
    test_eieos();
    test_restart();
    test_bubbles();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
